hazard_scoreboard: RTL
======================

# hazard_scoreboard

Producer-side hazard tracker for the 5-stage pipeline. Records every in-flight register writer from issue (ID→ID/EX) to retirement (WB) and detects the load-use hazards that MEM/WB forwarding cannot cover. On such a hazard it stalls the PC and IF/ID and inserts a bubble into ID/EX. It also exports a per-register pending mask, a stall-cycle counter and a sticky consistency error.

## Interface
- NUM_REGS, 32, architectural registers tracked (x0 never tracked)
- REG_W, 5, register index width
- CNT_W, 16, stall counter width
---
- clk  in  1  pipeline clock, posedge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  valid instruction in ID
- id_rs1  in  REG_W  source register 1 of ID instruction
- id_rs2  in  REG_W  source register 2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_rd  in  REG_W  destination of ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a LOAD
- flush  in  1  squash ID instruction this cycle (branch/jump redirect)
- wb_valid  in  1  instruction retiring in WB
- wb_rd  in  REG_W  destination of retiring instruction
- wb_reg_write  in  1  retiring instruction writes rd
- stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- pending_mask  out  NUM_REGS  bit r = 1 while register r has ≥1 in-flight writer
- stall_count  out  CNT_W  saturating count of stall cycles
- sb_error  out  1  sticky: retire seen with no matching pending writer

## Operation
- State:
  - per-register 2-bit pending counter cnt[r], r=1..31
  - EX shadow slot {ex_v, ex_rd, ex_load}
  - stall_count
  - sb_error
- issue = id_valid & ~flush & ~stall.
- Writer tracking: issue & id_reg_write & id_rd≠0.
- Retire: wb_valid & wb_reg_write & wb_rd≠0.
- Load-use hazard: ex_v & ex_load & ex_rd≠0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Saturation hazard: writer issue targeting id_rd with cnt[id_rd]==3 and no same-cycle retire of id_rd.
- stall = id_valid & ~flush & (load-use | saturation).
- id_ex_bubble = stall | flush.
- Counter update per register r:
  - +1 on issue-write to r
  - −1 on retire of r
  - both in the same cycle: unchanged
  - retire of r with cnt[r]==0: cnt stays 0 and sb_error is set
- pending_mask[r] = (cnt[r]≠0); bit 0 is always 0.
- EX slot, every cycle:
  - on issue: ex_v←1, ex_rd←id_rd, ex_load←id_mem_read&id_reg_write
  - otherwise (stall, flush, no valid ID): ex_v←0
- stall_count increments by 1 each cycle stall=1 and holds at all-ones.
- sb_error is cleared only by reset.
- x0: never counted, never causes a hazard.

## Timing
- Reset (async, asserts immediately):
  - all cnt=0, ex_v=0, stall_count=0, sb_error=0
  - outputs stall=0, id_ex_bubble=0 (unless flush), pending_mask=0
- stall and id_ex_bubble are combinational from current inputs and registered state, valid in the same cycle.
- All state updates at posedge clk.
- A load-use hazard produces exactly one stall cycle. The next cycle ex_v=0, so stall deasserts and the consumer issues with the load in MEM, reaching the operand through WB forwarding.
- pending_mask reflects an issued writer from the cycle after issue through the cycle of its WB (clears after that edge).
- Flush and hazard in the same cycle: flush wins. stall=0, id_ex_bubble=1, no counter change from ID.
- Reset deasserted mid-stream: the first cycle after reset behaves as an empty pipeline.

## Test plan
- Load-use stall: issue LOAD x5, then next cycle ID ADD reads rs1=x5.
  - stall=1 and id_ex_bubble=1 for one cycle; stall=0 the next cycle; stall_count=1.
  - pending_mask[5]=1 until WB retires x5, then 0.
- Non-load producer: ADDI x6 issued, then dependent ADD on x6 → stall stays 0 (forwarding case); pending_mask[6] 1 for 3 cycles.
- x0 and unused sources:
  - LOAD to x0 followed by a reader of x0 → no stall, pending_mask=0.
  - LOAD x7 followed by an instruction with id_use_rs2=0 and id_rs2=7 → no stall.
- Flush priority: load-use condition present with flush=1 → stall=0, id_ex_bubble=1, cnt unchanged, ex_v=0 next cycle.
- Same-cycle issue and retire of x9 with cnt[9]=1 → cnt[9] stays 1. Retire of x10 with cnt[10]=0 → sb_error=1 and stays 1 until reset.
- Asynchronous reset asserted mid-stall with cnt[3]=2 → pending_mask=0, stall=0, stall_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Bundle of ID-stage, WB-stage and hazard-control signals between the
// pipeline (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int CNT_W    = 16
);
   logic                id_valid;
   logic [REG_W-1:0]    id_rs1;
   logic [REG_W-1:0]    id_rs2;
   logic                id_use_rs1;
   logic                id_use_rs2;
   logic [REG_W-1:0]    id_rd;
   logic                id_reg_write;
   logic                id_mem_read;
   logic                flush;
   logic                wb_valid;
   logic [REG_W-1:0]    wb_rd;
   logic                wb_reg_write;
   logic                stall;
   logic                id_ex_bubble;
   logic [NUM_REGS-1:0] pending_mask;
   logic [CNT_W-1:0]    stall_count;
   logic                sb_error;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, flush, wb_valid, wb_rd, wb_reg_write,
      input  stall, id_ex_bubble, pending_mask, stall_count, sb_error
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
             id_reg_write, id_mem_read, flush, wb_valid, wb_rd, wb_reg_write,
      output stall, id_ex_bubble, pending_mask, stall_count, sb_error
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker: counts in-flight writers per register from
// issue to WB retirement, stalls on load-use hazards and on writer-count
// saturation, and reports a pending mask, stall-cycle count and sticky error.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int CNT_W    = 16
) (
   input logic               clk,
   input logic               reset,
   hazard_scoreboard_if.slave bus
);

   // Per-register pending counters and error flags, gathered for lookup.
   logic [1:0]       w_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_err;

   // Shadow of the instruction currently in EX.
   logic             r_ex_v;
   logic [REG_W-1:0] r_ex_rd;
   logic             r_ex_load;
   logic [CNT_W-1:0] r_stall_count;

   logic w_issue;
   logic w_wr_issue;
   logic w_retire;
   logic w_load_use;
   logic w_sat;
   logic w_stall;

   // A retirement of id_rd in the same cycle frees a slot, so a fourth
   // writer may then issue without overflowing the 2-bit counter.
   assign w_retire   = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != '0);
   assign w_load_use = r_ex_v & r_ex_load & (r_ex_rd != '0) & bus.id_valid &
                       ((bus.id_use_rs1 & (bus.id_rs1 == r_ex_rd)) |
                        (bus.id_use_rs2 & (bus.id_rs2 == r_ex_rd)));
   assign w_sat      = bus.id_reg_write & (bus.id_rd != '0) &
                       (w_cnt[bus.id_rd] == 2'd3) &
                       ~(w_retire & (bus.wb_rd == bus.id_rd));
   // Flush always wins over a hazard: the squashed instruction never issues.
   assign w_stall    = bus.id_valid & ~bus.flush & (w_load_use | w_sat);
   assign w_issue    = bus.id_valid & ~bus.flush & ~w_stall;
   assign w_wr_issue = w_issue & bus.id_reg_write & (bus.id_rd != '0);

   assign bus.stall        = w_stall;
   assign bus.id_ex_bubble = w_stall | bus.flush;
   assign bus.stall_count  = r_stall_count;
   assign bus.sb_error     = |w_err;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (gi == 0) begin : g_x0
            assign w_cnt[gi]            = 2'd0;
            assign w_err[gi]            = 1'b0;
            assign bus.pending_mask[gi] = 1'b0;
         end else begin : g_rx
            logic [1:0] r_cnt;
            logic       r_err;
            logic       w_inc;
            logic       w_dec;

            assign w_inc = w_wr_issue & (bus.id_rd == REG_W'(gi));
            assign w_dec = w_retire & (bus.wb_rd == REG_W'(gi));

            // Track in-flight writers of this register; flag retires with none pending.
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  r_cnt <= 2'd0;
                  r_err <= 1'b0;
               end else begin
                  if (w_dec && (r_cnt == 2'd0))
                     r_err <= 1'b1;
                  if (w_inc && !w_dec)
                     r_cnt <= r_cnt + 2'd1;
                  else if (w_dec && !w_inc && (r_cnt != 2'd0))
                     r_cnt <= r_cnt - 2'd1;
               end
            end

            assign w_cnt[gi]            = r_cnt;
            assign w_err[gi]            = r_err;
            assign bus.pending_mask[gi] = (r_cnt != 2'd0);
         end
      end
   endgenerate

   // Capture the issuing instruction into the EX shadow; bubbles clear it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex_v    <= 1'b0;
         r_ex_rd   <= '0;
         r_ex_load <= 1'b0;
      end else if (w_issue) begin
         r_ex_v    <= 1'b1;
         r_ex_rd   <= bus.id_rd;
         r_ex_load <= bus.id_mem_read & bus.id_reg_write;
      end else begin
         r_ex_v    <= 1'b0;
      end
   end

   // Count stall cycles, holding at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_stall_count <= '0;
      else if (w_stall && !(&r_stall_count))
         r_stall_count <= r_stall_count + CNT_W'(1);
   end

endmodule
